// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Covers access-size encoding, sequencer states, alignment check and load extension.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Misaligned word/half accesses and the reserved size code are errors.
  function automatic logic access_err(input size_e size, input logic [1:0] lsb);
    logic err;
    case (size)
      SZ_WORD: err = (lsb != 2'b00);
      SZ_HALF: err = lsb[0];
      SZ_BYTE: err = 1'b0;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic signed [31:0] extend_load(input size_e size, input logic uns,
                                                     input logic [31:0] data);
    logic signed [31:0] ext;
    case (size)
      SZ_BYTE: ext = {{24{data[7] & ~uns}}, data[7:0]};
      SZ_HALF: ext = {{16{data[15] & ~uns}}, data[15:0]};
      default: ext = data;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the port that was not served last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       grant
);

  assign any = |valid;

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else if (valid[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported data memory between fetch (port 0) and load/store
// (port 1): one transaction in flight, IDLE -> ACCESS -> RESP per request.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ-1:0][1:0]          req_size,
  input  logic [NUM_REQ-1:0]               req_unsigned,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][31:0]         req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [NUM_REQ-1:0][31:0]         rsp_rdata,
  output logic [NUM_REQ-1:0]               rsp_err,
  output logic                             mem_we,
  output logic [1:0]                       mem_size,
  output logic [31:0]                      mem_addr,
  output logic [31:0]                      mem_wdata,
  input  logic [31:0]                      mem_rdata
);

  state_e              state, state_n;
  logic                last_grant;
  logic                pick, any_req, take;
  logic                l_gnt, l_we, l_uns, l_err;
  size_e               l_size;
  logic [ADDR_W-1:0]   l_addr;
  logic [31:0]         l_wdata;
  logic signed [31:0]  rdata_q;
  logic                sel_err;

  rr_arb2 u_arb (
    .valid      (req_valid[1:0]),
    .last_grant (last_grant),
    .any        (any_req),
    .grant      (pick)
  );

  assign sel_err = access_err(size_e'(req_size[pick]), req_addr[pick][1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are decoded from state so a reset in any cycle clears them at once.
  always_comb begin
    state_n   = state;
    take      = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    mem_we    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[pick] = 1'b1;
          take            = 1'b1;
          state_n         = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = l_we & ~l_err;
        mem_size  = l_size;
        mem_addr  = 32'(l_addr);
        mem_wdata = l_wdata;
        state_n   = RESP;
      end
      RESP: begin
        rsp_valid[l_gnt] = 1'b1;
        rsp_err[l_gnt]   = l_err;
        rsp_rdata[l_gnt] = rdata_q;
        if (rsp_ready[l_gnt]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      l_gnt      <= 1'b0;
      l_we       <= 1'b0;
      l_uns      <= 1'b0;
      l_err      <= 1'b0;
      l_size     <= SZ_WORD;
      l_addr     <= '0;
      l_wdata    <= '0;
      rdata_q    <= '0;
    end else begin
      if (take) begin
        l_gnt   <= pick;
        l_we    <= req_we[pick];
        l_uns   <= req_unsigned[pick];
        l_err   <= sel_err;
        l_size  <= size_e'(req_size[pick]);
        l_addr  <= req_addr[pick];
        l_wdata <= req_wdata[pick];
      end
      // Read data is captured on the edge that ends ACCESS.
      if (state == ACCESS) begin
        rdata_q <= (l_we || l_err) ? '0 : extend_load(l_size, l_uns, mem_rdata);
      end
      if (state == RESP && rsp_ready[l_gnt]) begin
        last_grant <= l_gnt;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed memory model.
module tb_mem_port_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready, req_we, req_unsigned;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             mem_load;
  logic [7:0]       mem [0:63];
  logic [5:0]       ma0, ma1, ma2, ma3;
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign ma0 = mem_addr[5:0];
  assign ma1 = ma0 + 6'd1;
  assign ma2 = ma0 + 6'd2;
  assign ma3 = ma0 + 6'd3;

  always_comb begin
    case (mem_size)
      2'b01:   mem_rdata = {24'h0, mem[ma0]};
      2'b10:   mem_rdata = {16'h0, mem[ma1], mem[ma0]};
      default: mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    endcase
  end

  // Preload image: half 0x8001 at 0x02, word 0x11223344 at 0x04, 0xDEADBEEF at 0x08.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[2]  <= 8'h01; mem[3]  <= 8'h80;
      mem[4]  <= 8'h44; mem[5]  <= 8'h33; mem[6]  <= 8'h22; mem[7]  <= 8'h11;
      mem[8]  <= 8'hEF; mem[9]  <= 8'hBE; mem[10] <= 8'hAD; mem[11] <= 8'hDE;
    end else if (mem_we) begin
      case (mem_size)
        2'b01: mem[ma0] <= mem_wdata[7:0];
        2'b10: begin
          mem[ma0] <= mem_wdata[7:0];
          mem[ma1] <= mem_wdata[15:8];
        end
        default: begin
          mem[ma0] <= mem_wdata[7:0];
          mem[ma1] <= mem_wdata[15:8];
          mem[ma2] <= mem_wdata[23:16];
          mem[ma3] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid[p]    = 1'b1;
    req_we[p]       = we;
    req_size[p]     = sz;
    req_unsigned[p] = uns;
    req_addr[p]     = addr;
    req_wdata[p]    = wd;
  endtask

  // Full single-port transaction: accept, access, response, handshake.
  task automatic txn(input string tag, input int p, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    set_req(p, we, sz, uns, addr, wd);
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(1 << p));
    tick();
    req_valid[p] = 1'b0;
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we & ~exp_err));
    chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
    tick();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1 << p));
    chk({tag, ".rdata"}, rsp_rdata[p], exp_rd);
    chk({tag, ".err"}, 32'(rsp_err[p]), 32'(exp_err));
    rsp_ready[p] = 1'b1;
    tick();
    rsp_ready[p] = 1'b0;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    mem_load     = 1'b1;
    req_valid    = '0;
    req_we       = '0;
    req_unsigned = '0;
    req_size     = '0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = '0;
    tick();
    tick();
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.rdata", rsp_rdata[0] | rsp_rdata[1], 32'd0);
    reset_n  = 1'b1;
    mem_load = 1'b0;
    tick();

    // Both ports request continuously: grants alternate starting with port 0.
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr.req_ready", 32'(req_ready), 32'(1 << (i % 2)));
      tick();
      tick();
      chk("rr.rsp_valid", 32'(rsp_valid), 32'(1 << (i % 2)));
      chk("rr.rdata", rsp_rdata[i % 2], 32'hDEADBEEF);
      rsp_ready = 2'b11;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    tick();

    txn("lw08",    1, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0);
    txn("sb0b",    1, 1'b1, 2'b01, 1'b0, 32'h0B, 32'h00000080, 32'h0,        1'b0);
    txn("lb0b",    1, 1'b0, 2'b01, 1'b0, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0);
    txn("lbu0b",   1, 1'b0, 2'b01, 1'b1, 32'h0B, 32'h0,        32'h00000080, 1'b0);
    txn("lh02",    1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        32'hFFFF8001, 1'b0);
    txn("lhu02",   1, 1'b0, 2'b10, 1'b1, 32'h02, 32'h0,        32'h00008001, 1'b0);
    txn("sh05",    1, 1'b1, 2'b10, 1'b0, 32'h05, 32'h0000BEEF, 32'h0,        1'b1);
    txn("lw04a",   1, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0,        32'h11223344, 1'b0);
    txn("lw06",    1, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1);
    txn("szbad",   1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1);
    txn("sb05",    1, 1'b1, 2'b01, 1'b0, 32'h05, 32'h000000AB, 32'h0,        1'b0);
    txn("lw04b",   1, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0,        32'h1122AB44, 1'b0);

    // Port 0 stalls its response while port 1 waits.
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0);
    #1;
    chk("hold.grant0", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold.rsp_valid", 32'(rsp_valid), 32'b01);
      chk("hold.rdata", rsp_rdata[0], 32'h80ADBEEF);
      chk("hold.ready1", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    chk("hold.grant1", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    tick();
    chk("hold.rdata1", rsp_rdata[1], 32'h1122AB44);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;

    // Serve port 0 last so a post-reset tie shows last_grant returning to 1.
    txn("lw0c", 0, 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);

    set_req(0, 1'b1, 2'b00, 1'b0, 32'h0C, 32'h55667788);
    #1;
    chk("rst.sw_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    chk("rst.sw_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    tick();
    tick();
    chk("rst.mem_word", {mem[15], mem[14], mem[13], mem[12]}, 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst.tie_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("rst.rdata0", rsp_rdata[0], 32'h1122AB44);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    chk("rst.grant1", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    tick();
    chk("rst.rdata1", rsp_rdata[1], 32'h80ADBEEF);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
